miriscv_uart_tx: RTL and testbench

Memory-mapped UART transmitter attached to the miriscv_top data-memory bus as a downstream peripheral. It consumes core store transactions and serialises bytes onto tx_o as 8N1 frames. A small FIFO decouples the core from the line rate. The core can poll a status register and program the baud divisor.

---
 rtl/miriscv_uart_pkg.sv | 26 ++
 rtl/miriscv_uart_if.sv | 15 +
 rtl/miriscv_sync_fifo.sv | 54 +++++
 rtl/miriscv_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_miriscv_uart_tx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/miriscv_uart_pkg.sv
// Shared definitions for the miriscv memory-mapped UART transmitter:
// register offsets, STATUS bit positions and the transmit FSM encoding.
package miriscv_uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_EMPTY = 2;
    localparam int STATUS_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // A programmed divisor of zero behaves as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/miriscv_uart_if.sv
// Data-memory bus slice seen by the UART peripheral.
// Handshake: req_i is a single-cycle strobe with no ready/stall; every request
// is accepted in the cycle it is asserted, and read data appears on rdata_o
// the following cycle and holds until the next read.
interface miriscv_uart_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (output req_i, we_i, be_i, addr_i, wdata_i, input rdata_o);
    modport slave  (input req_i, we_i, be_i, addr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/miriscv_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module miriscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/miriscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter
// and frame FSM. tx_o is registered from the next-state output, so it is glitch-free.
module miriscv_uart_tx
    import miriscv_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd1736
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    miriscv_uart_if.slave         bus,
    output logic                  tx_o,
    output logic                  irq_o,
    output uart_state_e           state_o
);

    uart_state_e state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        wr_en, rd_en;
    logic [1:0]  reg_sel;
    logic [15:0] div_eff;
    logic        bit_done;
    logic [31:0] status;
    logic        unused_bus;

    assign wr_en     = bus.req_i & bus.we_i;
    assign rd_en     = bus.req_i & ~bus.we_i;
    assign reg_sel   = bus.addr_i[3:2];
    assign fifo_push = wr_en && (reg_sel == UART_TXDATA) && bus.be_i[0];
    assign div_eff   = eff_div(div_q);
    assign bit_done  = (cnt_q == 16'd0);
    assign unused_bus = ^{bus.wdata_i[31:16], bus.addr_i[1:0], bus.be_i[3:2]};

    always_comb begin
        status = '0;
        status[STATUS_BUSY]  = (state_q != IDLE);
        status[STATUS_FULL]  = fifo_full;
        status[STATUS_EMPTY] = fifo_empty;
        status[STATUS_OVF]   = ovf_q;
    end

    miriscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .wdata_i (bus.wdata_i[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Register writes and the registered read port.
    always_comb begin
        div_d   = div_q;
        ovf_d   = ovf_q;
        rdata_d = rdata_q;
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (wr_en && (reg_sel == UART_STATUS) && bus.be_i[0] &&
                     bus.wdata_i[STATUS_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_en && (reg_sel == UART_DIV)) begin
            if (bus.be_i[0]) div_d[7:0]  = bus.wdata_i[7:0];
            if (bus.be_i[1]) div_d[15:8] = bus.wdata_i[15:8];
        end
        if (rd_en) begin
            case (reg_sel)
                UART_STATUS: rdata_d = status;
                UART_DIV:    rdata_d = {16'b0, div_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    // The bit counter reloads from div_eff only at a bit boundary, so a
    // divisor write never stretches or cuts the bit currently on the line.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_rdata;
                    cnt_d    = div_eff - 16'd1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = div_eff - 16'd1;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = div_eff - 16'd1;
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_rdata;
                        cnt_d    = div_eff - 16'd1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
        irq_d = fifo_empty & (state_q == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            div_q   <= DIV_RESET;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign tx_o        = tx_q;
    assign irq_o       = irq_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Directed bench for miriscv_uart_tx: register access, cycle-exact frames,
// FIFO burst with overflow, and asynchronous reset in the middle of a frame.
module tb_miriscv_uart_tx;
    import miriscv_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx;
    logic        irq;
    uart_state_e state;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    // Serial receiver and scoreboard
    logic        rx_en = 1'b0;
    int          rx_div = 4;
    int          rx_frm_err = 0;
    logic [7:0]  got_q[$];
    int unsigned start_q[$];
    logic [7:0]  exp_q[$];

    miriscv_uart_if bus();

    miriscv_uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd1736)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .tx_o    (tx),
        .irq_o   (irq),
        .state_o (state)
    );

    // Clock and reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: called at a negedge, return at the following negedge.
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = addr;
        bus.wdata_i = data;
        bus.be_i    = be;
        @(negedge clk);
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = addr;
        bus.be_i   = 4'b0000;
        @(negedge clk);
        data = bus.rdata_o;
        bus.req_i = 1'b0;
    endtask

    // Cycle-exact frame check starting one cycle after the TXDATA write edge.
    task automatic check_frame(input string tag, input logic [7:0] b, input int div);
        logic ev;
        for (int n = 1; n <= 10 * div + 2; n++) begin
            if (n < 2)               ev = 1'b1;
            else if (n < 2 + div)    ev = 1'b0;
            else if (n < 2 + 9 * div) ev = b[(n - 2 - div) / div];
            else                     ev = 1'b1;
            check_eq($sformatf("%s_tx_c%0d", tag, n), {31'b0, tx}, {31'b0, ev});
            if (n == 3) check_eq({tag, "_irq_mid"}, {31'b0, irq}, 32'd0);
            @(negedge clk);
        end
        check_eq({tag, "_irq_end"}, {31'b0, irq}, 32'd1);
    endtask

    // Background receiver sampling mid-bit; records byte and start cycle.
    initial begin
        logic [7:0] rb;
        int unsigned sc;
        forever begin
            @(negedge clk);
            if (rx_en && tx == 1'b0) begin
                sc = cyc;
                repeat (rx_div / 2) @(negedge clk);
                if (tx !== 1'b0) rx_frm_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (rx_div) @(negedge clk);
                    rb[i] = tx;
                end
                repeat (rx_div) @(negedge clk);
                if (tx !== 1'b1) rx_frm_err++;
                got_q.push_back(rb);
                start_q.push_back(sc);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  eb, gb;
        int          lows;

        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.be_i    = 4'b0;
        bus.addr_i  = 4'b0;
        bus.wdata_i = 32'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_irq", {31'b0, irq}, 32'd1);
        check_eq("rst_rdata", bus.rdata_o, 32'd0);
        check_eq("rst_state", 32'(state), 32'(IDLE));
        bus_read(4'h4, rd);
        check_eq("rst_status", rd, 32'h4);
        bus_read(4'h8, rd);
        check_eq("rst_div", rd, 32'd1736);

        // 0x55 frame at div 4
        bus_write(4'h8, 32'd4, 4'b0011);
        bus_write(4'h0, 32'h55, 4'b0001);
        check_frame("f55", 8'h55, 4);

        // Divisor zero clamps to one cycle per bit
        bus_write(4'h8, 32'd0, 4'b0011);
        bus_write(4'h0, 32'hA3, 4'b0001);
        check_frame("fa3_div0", 8'hA3, 1);

        // Burst: 9 accepted, 8 dropped, contiguous frames
        bus_write(4'h8, 32'd4, 4'b0011);
        rx_div = 4;
        got_q.delete();
        start_q.delete();
        rx_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus_write(4'h0, 32'(i), 4'b0001);
            exp_q.push_back(8'(i));
        end
        bus_read(4'h4, rd);
        check_eq("burst_full_no_ovf", rd, 32'h3);
        for (int i = 0; i < 8; i++) bus_write(4'h0, 32'h10 + 32'(i), 4'b1111);
        bus_read(4'h4, rd);
        check_eq("burst_ovf_status", rd, 32'hB);
        bus_write(4'h4, 32'h8, 4'b0001);
        bus_read(4'h4, rd);
        check_eq("burst_ovf_clear", rd, 32'h3);
        for (int k = 0; k < 600 && got_q.size() < 9; k++) @(negedge clk);
        check_eq("burst_frames", 32'(got_q.size()), 32'd9);
        for (int i = 1; i < start_q.size(); i++)
            check_eq($sformatf("burst_gap%0d", i), start_q[i] - start_q[i-1], 32'd40);
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            gb = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            check_eq("burst_byte", {24'b0, gb}, {24'b0, eb});
        end
        check_eq("burst_framing", 32'(rx_frm_err), 32'd0);
        rx_en = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(4'h4, rd);
        check_eq("burst_done_status", rd, 32'h4);
        check_eq("burst_done_irq", {31'b0, irq}, 32'd1);

        // Byte enables and reserved/readback addresses
        bus_write(4'h0, 32'hFF, 4'b1110);
        repeat (3) @(negedge clk);
        check_eq("be_nopush_tx", {31'b0, tx}, 32'd1);
        bus_read(4'h4, rd);
        check_eq("be_nopush_status", rd, 32'h4);
        bus_read(4'hC, rd);
        check_eq("reserved_read", rd, 32'h0);
        bus_read(4'h4, rd);
        bus_read(4'h0, rd);
        check_eq("txdata_read", rd, 32'h0);
        bus_write(4'hC, 32'hFFFF_FFFF, 4'b1111);
        bus_write(4'h8, 32'h0000_ABCD, 4'b0010);
        bus_read(4'h8, rd);
        check_eq("div_hi_byte", rd, 32'hAB04);
        bus_read(4'h8, rd);
        check_eq("rdata_hold", bus.rdata_o, 32'hAB04);
        bus_write(4'h8, 32'd4, 4'b0011);

        // Reset in the middle of a queued 3-byte burst
        for (int i = 0; i < 3; i++) bus_write(4'h0, 32'h0, 4'b0001);
        for (int k = 0; k < 20 && state != DATA; k++) @(negedge clk);
        check_eq("mid_reach_data", 32'(state), 32'(DATA));
        repeat (5) @(negedge clk);
        check_eq("mid_tx_low", {31'b0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", {31'b0, tx}, 32'd1);
        check_eq("mid_rst_state", 32'(state), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_rdata", bus.rdata_o, 32'd0);
        bus_read(4'h4, rd);
        check_eq("mid_rst_status", rd, 32'h4);
        bus_read(4'h8, rd);
        check_eq("mid_rst_div", rd, 32'd1736);
        lows = 0;
        for (int k = 0; k < 80; k++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check_eq("mid_rst_no_frames", 32'(lows), 32'd0);
        check_eq("mid_rst_irq", {31'b0, irq}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
